matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
- Upstream feeder for matrix_multiplier.
- Accepts matrix elements one at a time over a valid/ready stream: all of A in row-major order, then all of B.
- Assembles them into the packed a/b operand arrays and presents the complete pair with mat_valid.
- Holds both arrays stable until the consumer acknowledges with mat_ready, then reloads.

Parameters:
- DATA_WIDTH, 32, element width in bits
- ROWS_A, 2, rows of A and of C
- COLS_A, 2, columns of A and rows of B
- COLS_B, 2, columns of B and of C

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of a partial load
- in_data  input  DATA_WIDTH  element value
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader can accept an element
- a  output  [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]  assembled A
- b  output  [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]  assembled B
- mat_valid  output  1  a and b are complete and stable
- mat_ready  input  1  consumer has taken a/b

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state LOAD_A, all counters 0, a='0, b='0, mat_valid=0, in_ready=1 once rst_n deasserts.
- Transfer: occurs when in_valid && in_ready at a rising clk edge.
- States:
  - LOAD_A: in_ready=1. Each transfer writes a[r][c], with r/c counters stepping c first, wrapping at COLS_A and then ROWS_A. The transfer at r=ROWS_A-1, c=COLS_A-1 goes to LOAD_B with counters cleared.
  - LOAD_B: same rule into b[r][c], bounds COLS_A x COLS_B. The last transfer goes to HOLD.
  - HOLD: in_ready=0, mat_valid=1, a/b frozen. mat_ready=1 goes to LOAD_A next cycle, with mat_valid=0 that cycle.
- Timing:
  - mat_valid is registered. It asserts the cycle after the final B transfer.
  - Minimum load time is ROWS_A*COLS_A + COLS_A*COLS_B cycles.
  - in_ready is a function of the state register only; no combinational path from in_valid.
- HOLD boundary: in_valid during HOLD is ignored, and the element stays pending upstream. mat_ready outside HOLD is ignored.
- Matrix contents: a/b are not cleared between loads. Each element is overwritten by the next load.
- flush:
  - In LOAD_A/LOAD_B: return to LOAD_A with counters 0. A transfer in the same cycle is discarded.
  - In HOLD: also returns to LOAD_A and drops mat_valid.
  - flush and mat_ready together: flush wins, with the same end state.
- Reset mid-load: everything returns to reset values immediately, asynchronously.
- Arithmetic: no arithmetic on data. Counter widths are $clog2 of the bound, minimum 1 bit.

Optional Feature:
- Macro: MATRIX_LOADER_TRANSPOSE_B_EN.
- Defined: B arrives column-major. The row counter steps first, wrapping at COLS_A, then the column counter at COLS_B.
- Undefined: B arrives row-major, as above.
- A is always row-major. Port list is identical in both builds.

Decomposition:
- Package matrix_pkg holds:
  - state enum typedef loader_state_t {LOAD_A, LOAD_B, HOLD}
  - default dimension localparams shared with matrix_multiplier
- Natural sub-module: matrix_index_counter, a 2-D row/col counter.
  - Ports: clk, rst_n, clear, step, a wrap flag, r, c.
  - Parameterised by bounds and order.
  - Instantiated once, cleared on A-to-B change, HOLD exit and flush.

Test Plan:
- Basic load: stream 1,2,3,4,5,6,7,8 with in_valid constant -> after 8 transfers a={{1,2},{3,4}}, b={{5,6},{7,8}}, mat_valid=1 one cycle later, in_ready=0.
- Backpressure hold: keep mat_ready=0 for 10 cycles while in_valid=1 with data 9 -> a/b unchanged, no transfers; pulse mat_ready -> mat_valid=0, in_ready=1 next cycle.
- Gapped input: toggle in_valid every other cycle while streaming 1..8 -> same arrays as basic load, completing after 16 cycles.
- Flush mid-B: load A=1..4 and two B elements, assert flush, then stream 10..17 -> a={{10,11},{12,13}}, b={{14,15},{16,17}}.
- Async reset: drop rst_n in HOLD between clock edges -> mat_valid=0, a=b=0 immediately, in_ready=1 after release.
- Transposed B (macro defined): stream 1..8 -> b={{5,7},{6,8}}.

Source files
------------

// File: rtl/matrix_pkg.sv
//==============================================================================
// Module      : matrix_pkg
// Description : Shared types and default dimensions for the matrix datapath
//               (matrix_loader feeding matrix_multiplier).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package matrix_pkg;

    // Loader sequencing: fill A, fill B, then hold the pair for the consumer
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } loader_state_t;

    // Default dimensions shared by the loader and the multiplier
    localparam int MATRIX_DATA_WIDTH = 32;
    localparam int MATRIX_ROWS_A     = 2;
    localparam int MATRIX_COLS_A     = 2;
    localparam int MATRIX_COLS_B     = 2;

    // Index width for a counter over [0, bound-1]; never narrower than 1 bit
    function automatic int idx_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_index_counter.sv
//==============================================================================
// Module      : matrix_index_counter
// Description : Two-dimensional row/column index counter with two selectable
//               bound sets (set 0 for A, set 1 for B). Set 0 always steps the
//               column first; set 1 steps in the order given by COL_FIRST1.
//               wrap flags the last index of the active bound set.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int ROWS0      = 2,
    parameter int COLS0      = 2,
    parameter int ROWS1      = 2,
    parameter int COLS1      = 2,
    parameter bit COL_FIRST1 = 1'b1,
    localparam int RW        = idx_width(max2(ROWS0, ROWS1)),
    localparam int CW        = idx_width(max2(COLS0, COLS1))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    input  logic          clear,
    input  logic          step,
    output logic          wrap,
    output logic [RW-1:0] r,
    output logic [CW-1:0] c
);

    localparam logic [RW-1:0] R0_MAX = RW'(ROWS0 - 1);
    localparam logic [CW-1:0] C0_MAX = CW'(COLS0 - 1);
    localparam logic [RW-1:0] R1_MAX = RW'(ROWS1 - 1);
    localparam logic [CW-1:0] C1_MAX = CW'(COLS1 - 1);

    logic [RW-1:0] r_q, r_d, r_max;
    logic [CW-1:0] c_q, c_d, c_max;
    logic          col_first;
    logic          r_end;
    logic          c_end;

    // Active bounds and end-of-row/column detection
    always_comb begin
        r_max     = sel ? R1_MAX : R0_MAX;
        c_max     = sel ? C1_MAX : C0_MAX;
        col_first = sel ? COL_FIRST1 : 1'b1;
        r_end     = (r_q == r_max);
        c_end     = (c_q == c_max);
        wrap      = r_end && c_end;
    end

    // Next index: clear has priority, the final step wraps both to zero
    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clear) begin
            r_d = '0;
            c_d = '0;
        end else if (step) begin
            if (wrap) begin
                r_d = '0;
                c_d = '0;
            end else if (col_first) begin
                if (c_end) begin
                    c_d = '0;
                    r_d = r_q + RW'(1);
                end else begin
                    c_d = c_q + CW'(1);
                end
            end else begin
                if (r_end) begin
                    r_d = '0;
                    c_d = c_q + CW'(1);
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
        end
    end

    // Index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign r = r_q;
    assign c = c_q;

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
//==============================================================================
// Module      : matrix_loader
// Description : Streams matrix elements (all of A row-major, then all of B)
//               into packed operand arrays and presents the complete pair
//               with mat_valid until mat_ready acknowledges it.
//               Build option MATRIX_LOADER_TRANSPOSE_B_EN: B arrives
//               column-major instead of row-major.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
    parameter int ROWS_A     = MATRIX_ROWS_A,
    parameter int COLS_A     = MATRIX_COLS_A,
    parameter int COLS_B     = MATRIX_COLS_B
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic [DATA_WIDTH-1:0]                        in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a,
    output logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b,
    output logic                                         mat_valid,
    input  logic                                         mat_ready
);

    localparam int RW  = idx_width(max2(ROWS_A, COLS_A));
    localparam int CW  = idx_width(max2(COLS_A, COLS_B));
    localparam int RAW = idx_width(ROWS_A);
    localparam int CAW = idx_width(COLS_A);
    localparam int RBW = idx_width(COLS_A);
    localparam int CBW = idx_width(COLS_B);

`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    localparam bit B_COL_FIRST = 1'b0;
`else
    localparam bit B_COL_FIRST = 1'b1;
`endif

    loader_state_t state_q, state_d;

    logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a_q;
    logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b_q;
    logic                                          mat_valid_q, mat_valid_d;

    logic          in_ready_w;
    logic          xfer;
    logic          cnt_clear;
    logic          cnt_step;
    logic          cnt_wrap;
    logic          sel_b;
    logic          wr_a;
    logic          wr_b;
    logic [RW-1:0] idx_r;
    logic [CW-1:0] idx_c;

    // Shared element index; bound set 1 (B) is chosen while loading B
    matrix_index_counter #(
        .ROWS0      (ROWS_A),
        .COLS0      (COLS_A),
        .ROWS1      (COLS_A),
        .COLS1      (COLS_B),
        .COL_FIRST1 (B_COL_FIRST)
    ) u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel_b),
        .clear (cnt_clear),
        .step  (cnt_step),
        .wrap  (cnt_wrap),
        .r     (idx_r),
        .c     (idx_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush always returns to LOAD_A, ahead of any other event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: begin
                if (flush)                  state_d = LOAD_A;
                else if (xfer && cnt_wrap)  state_d = LOAD_B;
            end
            LOAD_B: begin
                if (flush)                  state_d = LOAD_A;
                else if (xfer && cnt_wrap)  state_d = HOLD;
            end
            HOLD: begin
                if (flush || mat_ready)     state_d = LOAD_A;
            end
            default:                        state_d = LOAD_A;
        endcase
    end

    // Outputs and datapath controls; in_ready depends on state only
    always_comb begin
        in_ready_w  = (state_q != HOLD);
        sel_b       = (state_q == LOAD_B);
        xfer        = in_valid && in_ready_w;
        cnt_step    = xfer && !flush;
        cnt_clear   = flush || (xfer && cnt_wrap) || ((state_q == HOLD) && mat_ready);
        wr_a        = cnt_step && (state_q == LOAD_A);
        wr_b        = cnt_step && (state_q == LOAD_B);
        mat_valid_d = (state_d == HOLD);
    end

    // Operand storage and registered mat_valid; arrays are only overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            mat_valid_q <= 1'b0;
        end else begin
            mat_valid_q <= mat_valid_d;
            if (wr_a) begin
                a_q[idx_r[RAW-1:0]][idx_c[CAW-1:0]] <= in_data;
            end
            if (wr_b) begin
                b_q[idx_r[RBW-1:0]][idx_c[CBW-1:0]] <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_w;
    assign mat_valid = mat_valid_q;
    assign a         = a_q;
    assign b         = b_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
//==============================================================================
// Module      : tb_matrix_loader
// Description : Self-checking bench for matrix_loader with a linear-index
//               reference model. Honours MATRIX_LOADER_TRANSPOSE_B_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_matrix_loader;

    localparam int DW = 32;
    localparam int RA = 2;
    localparam int CA = 2;
    localparam int CB = 2;
    localparam int NA = RA * CA;
    localparam int NB = CA * CB;

    logic                         clk;
    logic                         rst_n;
    logic                         flush;
    logic [DW-1:0]                in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [RA-1:0][CA-1:0][DW-1:0] a;
    logic [CA-1:0][CB-1:0][DW-1:0] b;
    logic                         mat_valid;
    logic                         mat_ready;

    matrix_loader #(
        .DATA_WIDTH (DW),
        .ROWS_A     (RA),
        .COLS_A     (CA),
        .COLS_B     (CB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = filling A, 1 = filling B, 2 = holding
    int                            m_ph;
    int                            m_k;
    logic [RA-1:0][CA-1:0][DW-1:0] m_a;
    logic [CA-1:0][CB-1:0][DW-1:0] m_b;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        m_k  = 0;
        m_a  = '0;
        m_b  = '0;
    endtask

    // Effect of one rising edge given the inputs held across it
    task automatic model_step(input bit v, input logic [DW-1:0] d, input bit mr, input bit fl);
        if (fl) begin
            m_ph = 0;
            m_k  = 0;
        end else if (m_ph == 2) begin
            if (mr) begin
                m_ph = 0;
                m_k  = 0;
            end
        end else if (v) begin
            if (m_ph == 0) begin
                m_a[m_k / CA][m_k % CA] = d;
                m_k++;
                if (m_k == NA) begin
                    m_ph = 1;
                    m_k  = 0;
                end
            end else begin
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
                m_b[m_k % CA][m_k / CA] = d;
`else
                m_b[m_k / CB][m_k % CB] = d;
`endif
                m_k++;
                if (m_k == NB) begin
                    m_ph = 2;
                    m_k  = 0;
                end
            end
        end
    endtask

    // One cycle: check outputs at the falling edge, then drive the next inputs
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit mr, input bit fl);
        @(negedge clk);
        check("in_ready",  {255'd0, in_ready},  {255'd0, (m_ph != 2)});
        check("mat_valid", {255'd0, mat_valid}, {255'd0, (m_ph == 2)});
        check("a", {128'd0, a}, {128'd0, m_a});
        check("b", {128'd0, b}, {128'd0, m_b});
        in_valid  = v;
        in_data   = d;
        mat_ready = mr;
        flush     = fl;
        model_step(v, d, mr, fl);
    endtask

    logic [RA-1:0][CA-1:0][DW-1:0] k_a;
    logic [CA-1:0][CB-1:0][DW-1:0] k_b;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        mat_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load 1..8 with in_valid held high
        for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, DW'(9), 1'b0, 1'b0);
        k_a[0][0] = 1; k_a[0][1] = 2; k_a[1][0] = 3; k_a[1][1] = 4;
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
        k_b[0][0] = 5; k_b[0][1] = 7; k_b[1][0] = 6; k_b[1][1] = 8;
`else
        k_b[0][0] = 5; k_b[0][1] = 6; k_b[1][0] = 7; k_b[1][1] = 8;
`endif
        check("basic_a", {128'd0, a}, {128'd0, k_a});
        check("basic_b", {128'd0, b}, {128'd0, k_b});
        check("basic_valid", {255'd0, mat_valid}, 256'd1);

        // Backpressure in HOLD, then acknowledge
        repeat (10) cyc(1'b1, DW'(9), 1'b0, 1'b0);
        cyc(1'b1, DW'(9), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Gapped input 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            cyc(1'b1, DW'(i), 1'b0, 1'b0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush mid-B with a simultaneous (discarded) transfer, then reload
        for (int i = 1; i <= 6; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, DW'(99), 1'b0, 1'b1);
        for (int i = 10; i <= 17; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        k_a[0][0] = 10; k_a[0][1] = 11; k_a[1][0] = 12; k_a[1][1] = 13;
        check("flush_a", {128'd0, a}, {128'd0, k_a});

        // Flush and mat_ready together in HOLD
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Load again and drop reset asynchronously while holding
        for (int i = 20; i < 28; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {255'd0, mat_valid}, 256'd0);
        check("rst_a", {128'd0, a}, 256'd0);
        check("rst_b", {128'd0, b}, 256'd0);
        in_valid  = 1'b0;
        mat_ready = 1'b0;
        flush     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0, ($urandom % 25) == 0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
